// File: rtl/std_smult_arb_if.sv
// Handshake/operand bundle for the two-requester shared multiplier.
// Optional grant statistics ports appear with STD_SMULT_ARB_STATS_EN.
interface std_smult_arb_if #(
    parameter int width = 32
);
    logic                    go_0;
    logic                    go_1;
    logic signed [width-1:0] left_0;
    logic signed [width-1:0] right_0;
    logic signed [width-1:0] left_1;
    logic signed [width-1:0] right_1;
    logic signed [width-1:0] out_0;
    logic signed [width-1:0] out_1;
    logic                    done_0;
    logic                    done_1;
    logic                    busy;
`ifdef STD_SMULT_ARB_STATS_EN
    logic [15:0]             stat_0;
    logic [15:0]             stat_1;

    modport master (
        output go_0, go_1,
        output left_0, right_0,
        output left_1, right_1,
        input  out_0, out_1,
        input  done_0, done_1, busy,
        input  stat_0, stat_1
    );

    modport slave (
        input  go_0, go_1,
        input  left_0, right_0,
        input  left_1, right_1,
        output out_0, out_1,
        output done_0, done_1, busy,
        output stat_0, stat_1
    );
`else
    modport master (
        output go_0, go_1,
        output left_0, right_0,
        output left_1, right_1,
        input  out_0, out_1,
        input  done_0, done_1, busy
    );

    modport slave (
        input  go_0, go_1,
        input  left_0, right_0,
        input  left_1, right_1,
        output out_0, out_1,
        output done_0, done_1, busy
    );
`endif
endinterface

// File: rtl/std_smult_arb.sv
// Round-robin arbiter sharing one signed multiplier between two ports.
// Define STD_SMULT_ARB_STATS_EN to add saturating per-port grant counters.
module std_smult_arb #(
    parameter int width = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    std_smult_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t                    state;
    state_t                    state_n;
    logic [1:0]                cnt;
    logic [1:0]                cnt_n;
    logic                      ptr;
    logic                      sel;
    logic                      gsel;
    logic                      grant;
    logic signed [width-1:0]   lhs;
    logic signed [width-1:0]   rhs;
    logic signed [width-1:0]   out_0_q;
    logic signed [width-1:0]   out_1_q;
    logic signed [2*width-1:0] lhs_x;
    logic signed [2*width-1:0] rhs_x;
    logic signed [width-1:0]   prod_lo;
    logic                      finish;

    assign lhs_x   = {{width{lhs[width-1]}}, lhs};
    assign rhs_x   = {{width{rhs[width-1]}}, rhs};
    assign prod_lo = width'(lhs_x * rhs_x);
    assign finish  = (state == MUL) && (state_n == DONE);

    // Next state, counter and grant selection.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        grant   = 1'b0;
        gsel    = ptr;
        unique case (state)
            IDLE: begin
                if (bus.go_0 && bus.go_1) begin
                    grant = 1'b1;
                    gsel  = ptr;
                end else if (bus.go_0) begin
                    grant = 1'b1;
                    gsel  = 1'b0;
                end else if (bus.go_1) begin
                    grant = 1'b1;
                    gsel  = 1'b1;
                end
                if (grant) begin
                    state_n = MUL;
                    cnt_n   = 2'd0;
                end
            end
            MUL: begin
                if (cnt == 2'd1) begin
                    state_n = DONE;
                    cnt_n   = 2'd0;
                end else begin
                    cnt_n = cnt + 2'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 2'd0;
            end
        endcase
    end

    // State and cycle counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Operand capture at grant, result writeback on entry to DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr     <= 1'b0;
            sel     <= 1'b0;
            lhs     <= '0;
            rhs     <= '0;
            out_0_q <= '0;
            out_1_q <= '0;
        end else begin
            if (grant) begin
                sel <= gsel;
                ptr <= ~gsel;
                lhs <= gsel ? bus.left_1  : bus.left_0;
                rhs <= gsel ? bus.right_1 : bus.right_0;
            end
            if (finish) begin
                if (sel) out_1_q <= prod_lo;
                else     out_0_q <= prod_lo;
            end
        end
    end

    assign bus.out_0  = out_0_q;
    assign bus.out_1  = out_1_q;
    assign bus.done_0 = (state == DONE) && !sel;
    assign bus.done_1 = (state == DONE) && sel;
    assign bus.busy   = (state != IDLE);

`ifdef STD_SMULT_ARB_STATS_EN
    logic [15:0] stat_0_q;
    logic [15:0] stat_1_q;

    // Saturating grant counters, one per port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_0_q <= 16'd0;
            stat_1_q <= 16'd0;
        end else if (grant) begin
            if (!gsel && stat_0_q != 16'hFFFF)
                stat_0_q <= stat_0_q + 16'd1;
            if (gsel && stat_1_q != 16'hFFFF)
                stat_1_q <= stat_1_q + 16'd1;
        end
    end

    assign bus.stat_0 = stat_0_q;
    assign bus.stat_1 = stat_1_q;
`endif
endmodule

// File: doc/std_smult_arb.md
STD_SMULT_ARB -- requirements
Module: std_smult_arb

Interface
REQ-001 SHALL have parameter: width, 32, operand/result bit width (two's complement, >=2).
REQ-002 SHALL have port: clk  input  1  sole clock; all state rising-edge triggered.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: go_0, go_1  input  1  per-requester start request, held until matching done.
REQ-005 SHALL have ports: left_0, right_0, left_1, right_1  input  width  signed operands per requester.
REQ-006 SHALL have ports: out_0, out_1  output  width  signed registered product per requester.
REQ-007 SHALL have ports: done_0, done_1  output  1  one-cycle completion pulse per requester.
REQ-008 SHALL have port: busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-009 SHALL share one internal signed multiplier between two requesters through FSM states IDLE, MUL, DONE.
REQ-010 In IDLE with exactly one go_i high, SHALL grant requester i, latch left_i/right_i and i at the clock edge, then enter MUL.
REQ-011 In IDLE with go_0 and go_1 both high, SHALL grant the requester selected by a round-robin pointer; pointer SHALL point to the non-granted port after every grant.
REQ-012 SHALL stay in MUL for exactly 2 cycles via a 2-bit counter, then enter DONE.
REQ-013 On entry to DONE, SHALL load out_i with the low width bits of the full 2*width signed product of the latched operands; the other port's out SHALL be unchanged.
REQ-014 SHALL assert done_i for exactly the single DONE cycle, i.e. 3 cycles after the grant edge; done_(1-i) SHALL stay 0.
REQ-015 SHALL return from DONE to IDLE unconditionally; no grant SHALL occur in DONE, so go_i still high during its done pulse is never re-granted that cycle.
REQ-016 Throughput SHALL be one operation per 4 cycles maximum (IDLE, MUL, MUL, DONE).
REQ-017 go_i changes during MUL/DONE SHALL be ignored; a granted operation SHALL always complete and pulse done_i even if go_i drops.
REQ-018 Operand changes after the grant edge SHALL NOT affect the result.
REQ-019 out_i SHALL hold its value until the next completion for port i.
REQ-020 Overflow SHALL wrap (truncate), no saturation, no flag.

Reset
REQ-021 reset_n low SHALL immediately force state IDLE, counter 0, pointer to port 0, out_0=out_1=0, done_0=done_1=0, busy=0.
REQ-022 Reset during MUL or DONE SHALL discard the operation with no done pulse after release.
REQ-023 First grant after reset release SHALL occur on the first rising edge with reset_n high and some go_i high.

Configuration
REQ-024 Macro STD_SMULT_ARB_STATS_EN SHALL control grant statistics.
REQ-025 With STD_SMULT_ARB_STATS_EN defined, SHALL add outputs stat_0, stat_1 (16 bits each), incrementing on each grant to that port, saturating at 16'hFFFF, cleared by reset.
REQ-026 Without STD_SMULT_ARB_STATS_EN, stat ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-027 width=8, go_0 with left_0=-3, right_0=7 -> done_0 pulses 3 cycles after grant edge, out_0=8'hEB (-21), out_1 stays 0.
REQ-028 width=8, go_1 with 100*3 -> out_1=8'h2C (wrap of 300), done_1 single cycle, done_0 low.
REQ-029 After reset, go_0 and go_1 held together -> port 0 completes first, port 1 granted the IDLE cycle after done_0, done pulses exactly 4 cycles apart.
REQ-030 reset_n pulsed low in second MUL cycle -> outputs all 0 immediately, no done pulse afterwards, next simultaneous request granted to port 0.
REQ-031 go_0 dropped one cycle after grant, operands changed -> done_0 still pulses 3 cycles after grant, result uses original operands.
REQ-032 STD_SMULT_ARB_STATS_EN defined, 5 grants port 0 and 3 port 1 -> stat_0=5, stat_1=3; forced stat_0=16'hFFFF plus one grant -> stays 16'hFFFF.
